// File: rtl/ac_zone_ctrl_pkg.sv
`default_nettype none
// ==================================================================
// ac_pkg : shared types, mode encodings and sensor-fault helper
// Revision: 1.0
// ==================================================================
package ac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HEAT = 2'd1,
      COOL = 2'd2
   } zone_state_t;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_HEAT = 2'b01;
   localparam logic [1:0] MODE_COOL = 2'b10;
   localparam logic [1:0] MODE_AUTO = 2'b11;

   // A reading pinned at either rail means an open or shorted sensor.
   function automatic logic is_sensor_fault(input logic [31:0] t, input int unsigned w);
      logic [31:0] all_ones;
      all_ones = (32'd1 << w) - 32'd1;
      return (t == 32'd0) || (t == all_ones);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ac_zone_ctrl_if.sv
`default_nettype none
// ==================================================================
// ac_zone_ctrl_if : sensor/mode inputs and actuator outputs bundle
// Revision: 1.0
// ==================================================================
interface ac_zone_ctrl_if #(
   parameter int NZONES = 2,
   parameter int TEMP_W = 5
);
   localparam int CNT_W = $clog2(NZONES + 1);

   logic [NZONES*TEMP_W-1:0] temp;
   logic [1:0]               mode;
   logic [NZONES-1:0]        heating;
   logic [NZONES-1:0]        cooling;
   logic [NZONES-1:0]        fault;
   logic [CNT_W-1:0]         active_cnt;

   modport master (output temp, mode, input heating, cooling, fault, active_cnt);
   modport slave  (input temp, mode, output heating, cooling, fault, active_cnt);
endinterface
`default_nettype wire

// File: rtl/ac_zone_fsm.sv
`default_nettype none
// ==================================================================
// ac_zone_fsm : one zone's thermostat, dwell counter and fault flag
// Revision: 1.0
// ==================================================================
module ac_zone_fsm
   import ac_pkg::*;
#(
   parameter int TEMP_W    = 5,
   parameter int HEAT_ON   = 18,
   parameter int COOL_ON   = 22,
   parameter int TARGET    = 20,
   parameter int MIN_DWELL = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [TEMP_W-1:0] temp,
   input  logic [1:0]        mode,
   output logic              heating,
   output logic              cooling,
   output logic              fault,
   output logic              busy_d
);
   localparam int                CNT_W     = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
   localparam logic [CNT_W-1:0]  DWELL_MAX = CNT_W'(MIN_DWELL - 1);
   localparam logic [TEMP_W-1:0] HEAT_ON_T = TEMP_W'(HEAT_ON);
   localparam logic [TEMP_W-1:0] COOL_ON_T = TEMP_W'(COOL_ON);
   localparam logic [TEMP_W-1:0] TARGET_T  = TEMP_W'(TARGET);

   zone_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic             heating_q, cooling_q;
   logic             dwell_ok;
   logic             heat_allowed, cool_allowed;

   assign dwell_ok     = (cnt_q == DWELL_MAX);
   assign heat_allowed = (mode == MODE_HEAT) || (mode == MODE_AUTO);
   assign cool_allowed = (mode == MODE_COOL) || (mode == MODE_AUTO);

   always_comb begin
      fault_d = fault_q | is_sensor_fault(32'(temp), TEMP_W);
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dwell_ok) begin
               if (temp <= HEAT_ON_T && heat_allowed)
                  state_d = HEAT;
               else if (temp >= COOL_ON_T && cool_allowed)
                  state_d = COOL;
            end
         end
         HEAT: begin
            if (!heat_allowed || (dwell_ok && temp >= TARGET_T))
               state_d = IDLE;
         end
         COOL: begin
            if (!cool_allowed || (dwell_ok && temp <= TARGET_T))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A fault overrides everything, including the dwell hold.
      if (fault_d)
         state_d = IDLE;

      if (state_d != state_q)
         cnt_d = '0;
      else if (cnt_q == DWELL_MAX)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= DWELL_MAX;
         fault_q   <= 1'b0;
         heating_q <= 1'b0;
         cooling_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fault_q   <= fault_d;
         heating_q <= (state_d == HEAT);
         cooling_q <= (state_d == COOL);
      end
   end

   assign heating = heating_q;
   assign cooling = cooling_q;
   assign fault   = fault_q;
   assign busy_d  = (state_d != IDLE);

endmodule
`default_nettype wire

// File: rtl/ac_zone_ctrl.sv
`default_nettype none
// ==================================================================
// ac_zone_ctrl : multi-zone air-conditioning controller top level
// Revision: 1.0
// ==================================================================
module ac_zone_ctrl
   import ac_pkg::*;
#(
   parameter int NZONES    = 2,
   parameter int TEMP_W    = 5,
   parameter int HEAT_ON   = 18,
   parameter int COOL_ON   = 22,
   parameter int TARGET    = 20,
   parameter int MIN_DWELL = 4
) (
   input  logic          clk,
   input  logic          rst,
   ac_zone_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(NZONES + 1);

   generate
      if (NZONES < 1 || MIN_DWELL < 1 || !(HEAT_ON > 0 && HEAT_ON < TARGET &&
          TARGET < COOL_ON && COOL_ON < (1 << TEMP_W) - 1)) begin : g_bad_params
         $error("ac_zone_ctrl: illegal parameter set");
      end
   endgenerate

   logic [NZONES-1:0] busy_d;
   logic [CNT_W-1:0]  active_cnt_q, active_cnt_d;

   generate
      for (genvar z = 0; z < NZONES; z++) begin : g_zone
         ac_zone_fsm #(
            .TEMP_W    (TEMP_W),
            .HEAT_ON   (HEAT_ON),
            .COOL_ON   (COOL_ON),
            .TARGET    (TARGET),
            .MIN_DWELL (MIN_DWELL)
         ) u_zone (
            .clk     (clk),
            .rst     (rst),
            .temp    (bus.temp[z*TEMP_W +: TEMP_W]),
            .mode    (bus.mode),
            .heating (bus.heating[z]),
            .cooling (bus.cooling[z]),
            .fault   (bus.fault[z]),
            .busy_d  (busy_d[z])
         );
      end
   endgenerate

   // Counting next-state activity keeps active_cnt aligned with heating/cooling.
   always_comb begin
      active_cnt_d = '0;
      for (int z = 0; z < NZONES; z++)
         active_cnt_d = active_cnt_d + CNT_W'(busy_d[z]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         active_cnt_q <= '0;
      else
         active_cnt_q <= active_cnt_d;
   end

   assign bus.active_cnt = active_cnt_q;

endmodule
`default_nettype wire

// File: doc/ac_zone_ctrl.md
Name: ac_zone_ctrl

Overview:
- Multi-zone successor to the single-zone air-conditioning controller.
- NZONES independent zones, each with:
  - a hysteresis thermostat state machine (IDLE/HEAT/COOL),
  - a minimum-dwell anti-short-cycle counter,
  - a sticky sensor-fault detector.
- A shared mode input restricts the allowed actions. The block drives per-zone heating/cooling actuator enables from per-zone temperature sensors.

Parameters:
- NZONES, 2, number of zones (≥1).
- TEMP_W, 5, temperature width per zone, unsigned °C.
- HEAT_ON, 18, heat request threshold (temp ≤ HEAT_ON).
- COOL_ON, 22, cool request threshold (temp ≥ COOL_ON).
- TARGET, 20, release point for both HEAT and COOL.
- MIN_DWELL, 4, minimum cycles held in any state before a normal transition (≥1).
- Legal ordering: 0 < HEAT_ON < TARGET < COOL_ON < 2^TEMP_W-1. Elaboration error otherwise.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- temp  in  NZONES*TEMP_W  zone z at bits [z*TEMP_W +: TEMP_W].
- mode  in  2  00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO (common to all zones).
- heating  out  NZONES  heater enable per zone.
- cooling  out  NZONES  cooler enable per zone.
- fault  out  NZONES  sticky sensor fault per zone.
- active_cnt  out  $clog2(NZONES+1)  number of zones currently in HEAT or COOL.

Behaviour:
- Reset (async assert, applied immediately):
  - every zone goes to IDLE;
  - heating=0, cooling=0, fault=0, active_cnt=0;
  - dwell counter = MIN_DWELL-1, so the first transition after reset is unrestricted.
- Outputs are registered:
  - heating[z] = (state==HEAT), cooling[z] = (state==COOL).
  - Latency is 1 cycle: inputs sampled at edge k change outputs immediately after edge k.
- Dwell counter, per zone:
  - clears to 0 on any state change;
  - otherwise increments, saturating at MIN_DWELL-1;
  - dwell_ok = (count == MIN_DWELL-1), so every state lasts at least MIN_DWELL cycles unless exited by a forced exit.
- Sensor fault:
  - Raised when temp[z] == 0 or temp[z] == all-ones, sampled at an edge.
  - fault[z] sets at that edge and holds until rst.
  - While fault[z]=1 the zone is forced to IDLE and stays IDLE.
- Forced exits ignore dwell_ok and take effect at the same edge; the counter clears:
  - HEAT→IDLE when mode ∈ {OFF, COOL_ONLY} or fault;
  - COOL→IDLE when mode ∈ {OFF, HEAT_ONLY} or fault.
- Normal transitions (require dwell_ok, no fault):
  - IDLE→HEAT: temp ≤ HEAT_ON and mode ∈ {HEAT_ONLY, AUTO}.
  - IDLE→COOL: temp ≥ COOL_ON and mode ∈ {COOL_ONLY, AUTO}.
  - HEAT→IDLE: temp ≥ TARGET.
  - COOL→IDLE: temp ≤ TARGET.
  - No direct HEAT↔COOL transition; a zone always passes through IDLE, including its dwell.
- Hysteresis bands:
  - HEAT holds for HEAT_ON < temp < TARGET;
  - COOL holds for TARGET < temp < COOL_ON;
  - IDLE holds for HEAT_ON < temp < COOL_ON.
- Invariant: heating[z] & cooling[z] is never 1.
- active_cnt:
  - registered popcount of (heating|cooling), computed from next-state values so it stays coherent with the outputs in the same cycle;
  - range is 0..NZONES, with no wrap.
- Zones are fully independent; simultaneous events in different zones are all handled in the same cycle.

Decomposition:
- Package ac_pkg holds:
  - zone_state_t enum {IDLE, HEAT, COOL};
  - mode constants MODE_OFF, MODE_HEAT, MODE_COOL, MODE_AUTO;
  - helper function is_sensor_fault(temp).
- Sub-module ac_zone_fsm contains one zone's state, dwell counter and fault flag. It is instantiated NZONES times by a generate loop.
- The top level owns only the temp bus slicing and the active_cnt popcount register.

Test Plan (defaults NZONES=2, MIN_DWELL=4):
1. rst=1 mid-operation with zone0 in HEAT → heating=00, cooling=00, fault=00, active_cnt=0 before the next clock edge. After release, zone0 temp=17 in AUTO → heating[0]=1 after the first edge.
2. Zone0 heat dwell, AUTO:
   - temp=17 gives heating[0]=1; change to temp=20 one cycle later.
   - heating[0] stays 1 for exactly 4 cycles total, then 0.
   - temp=17 again at once → heating[0] stays 0 for 4 IDLE cycles, then returns to 1.
3. Zone1 cooling hysteresis:
   - temp=23 → cooling[1]=1;
   - after the dwell, temp=21 → cooling[1] stays 1;
   - temp=20 → cooling[1]=0 at the next edge;
   - active_cnt tracks correctly throughout.
4. Mode restriction:
   - HEAT_ONLY with zone1 temp=25 → cooling[1]=0 indefinitely.
   - With zone0 in HEAT, switch to OFF → heating[0]=0 at the very next edge (dwell ignored).
5. Sensor fault:
   - zone1 temp=31 → fault[1]=1 and cooling[1]=0;
   - temp returns to 25 → fault[1] stays 1 and the zone stays IDLE;
   - zone0 keeps operating normally; only rst clears fault[1].
6. Ramp: zone0 temp 17→26, incrementing every 2 cycles in AUTO → never heating[0]&cooling[0]; the HEAT→IDLE→COOL order is checked by assertion.
